// File: rtl/ahb_slave_mux_slave_7.sv
// ---------------------------------------------------------------------------
// ahb_slave_mux_slave_7
//   Address/data multiplexer sitting downstream of the slave-7 arbiter.
//   Routes the granted master's address phase to slave 7, steers write data
//   one accepted transfer later, and returns hready/hresp to the master that
//   owns each phase.
//
// Handshake: a transfer is accepted on a rising edge of hclk where
//   s_hreadyout = 1 and the presented s_htrans is NONSEQ or SEQ. While
//   s_hreadyout = 0 (hwait = 1) every phase owner is stalled and all data
//   phase state holds.
//
// Ports:
//   hclk, hreset        clock, synchronous active-high reset
//   hgrant, arb_hsel    one-hot grant and select from the slave-7 arbiter
//   m_h*                packed per-master address-phase signals and write data
//   s_hreadyout/hresp/hrdata   slave response inputs
//   s_h*                muxed address/data outputs to slave 7
//   m_hready, m_hresp   per-master ready/response
//   m_hrdata            read data broadcast to every master
//   hwait               ~s_hreadyout, back to the arbiter
//   mux_err             (only with AHB_SLAVE_MUX_ONEHOT_CHECK_EN) sticky flag
//                       for multi-hot grant or SEQ on a fresh grant
//   dbg_dp_state        data-phase FSM state (0 = DP_IDLE, 1 = DP_ACTIVE)
//   dbg_data_owner      master index owning the data phase
// ---------------------------------------------------------------------------
module ahb_slave_mux_slave_7 #(
  parameter int MASTER_NUM = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1
) (
  input  logic                             hclk,
  input  logic                             hreset,
  input  logic [MASTER_NUM-1:0]            hgrant,
  input  logic                             arb_hsel,
  input  logic [MASTER_NUM*ADDR_WIDTH-1:0] m_haddr,
  input  logic [MASTER_NUM*2-1:0]          m_htrans,
  input  logic [MASTER_NUM-1:0]            m_hwrite,
  input  logic [MASTER_NUM*3-1:0]          m_hsize,
  input  logic [MASTER_NUM*3-1:0]          m_hburst,
  input  logic [MASTER_NUM*DATA_WIDTH-1:0] m_hwdata,
  input  logic                             s_hreadyout,
  input  logic                             s_hresp,
  input  logic [DATA_WIDTH-1:0]            s_hrdata,
  output logic                             s_hsel,
  output logic [ADDR_WIDTH-1:0]            s_haddr,
  output logic [1:0]                       s_htrans,
  output logic                             s_hwrite,
  output logic [2:0]                       s_hsize,
  output logic [2:0]                       s_hburst,
  output logic [DATA_WIDTH-1:0]            s_hwdata,
  output logic [MASTER_NUM-1:0]            m_hready,
  output logic [MASTER_NUM-1:0]            m_hresp,
  output logic [DATA_WIDTH-1:0]            m_hrdata,
  output logic                             hwait,
`ifdef AHB_SLAVE_MUX_ONEHOT_CHECK_EN
  output logic                             mux_err,
`endif
  output logic                             dbg_dp_state,
  output logic [IDX_W-1:0]                 dbg_data_owner
);

  typedef enum logic {DP_IDLE = 1'b0, DP_ACTIVE = 1'b1} dp_state_t;

  // addr_owner_q/addr_valid_q remember who holds the address phase so it can
  // be replayed while the arbiter masks hgrant during a wait state.
  logic [IDX_W-1:0] addr_owner_q;
  logic             addr_valid_q;
  logic [IDX_W-1:0] data_owner_q;
  // The FSM state doubles as the data-active flag: DP_ACTIVE == data phase live.
  dp_state_t        dp_state, dp_state_next;

  logic             gnt_any;
  logic [IDX_W-1:0] gnt_idx;
  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             xfer_valid;
  logic             dp_active;

  assign hwait    = ~s_hreadyout;
  assign m_hrdata = s_hrdata;

  // Address select: fresh grant wins (lowest index if multi-hot); otherwise
  // replay the stalled owner while the slave is waiting.
  always_comb begin
    gnt_any = |hgrant;
    gnt_idx = '0;
    for (int i = MASTER_NUM - 1; i >= 0; i--) begin
      if (hgrant[i]) gnt_idx = IDX_W'(i);
    end
    sel_valid = 1'b0;
    sel_idx   = '0;
    if (gnt_any) begin
      sel_valid = 1'b1;
      sel_idx   = gnt_idx;
    end else if (hwait && addr_valid_q) begin
      sel_valid = 1'b1;
      sel_idx   = addr_owner_q;
    end
  end

  // Slave-side address-phase mux; all-zero (IDLE) without a selection.
  always_comb begin
    s_hsel   = 1'b0;
    s_haddr  = '0;
    s_htrans = 2'b00;
    s_hwrite = 1'b0;
    s_hsize  = 3'b000;
    s_hburst = 3'b000;
    if (sel_valid) begin
      s_hsel = arb_hsel;
      for (int i = 0; i < MASTER_NUM; i++) begin
        if (sel_idx == IDX_W'(i)) begin
          s_haddr  = m_haddr[i*ADDR_WIDTH +: ADDR_WIDTH];
          s_htrans = m_htrans[i*2 +: 2];
          s_hwrite = m_hwrite[i];
          s_hsize  = m_hsize[i*3 +: 3];
          s_hburst = m_hburst[i*3 +: 3];
        end
      end
    end
  end

  // NONSEQ (2'b10) and SEQ (2'b11) both have bit 1 set.
  assign xfer_valid = sel_valid && s_htrans[1];

  always_ff @(posedge hclk) begin
    if (hreset) begin
      addr_owner_q <= '0;
      addr_valid_q <= 1'b0;
      data_owner_q <= '0;
    end else begin
      if (gnt_any) begin
        addr_owner_q <= gnt_idx;
        addr_valid_q <= 1'b1;
      end else if (!hwait) begin
        addr_valid_q <= 1'b0;
      end
      if (s_hreadyout) data_owner_q <= sel_idx;
    end
  end

  // Data-phase FSM: state register
  always_ff @(posedge hclk) begin
    if (hreset) dp_state <= DP_IDLE;
    else        dp_state <= dp_state_next;
  end

  // Data-phase FSM: next state. Both states follow the same rule on a ready
  // edge, so a back-to-back transfer keeps the FSM in DP_ACTIVE with no bubble.
  always_comb begin
    dp_state_next = dp_state;
    if (s_hreadyout) dp_state_next = xfer_valid ? DP_ACTIVE : DP_IDLE;
  end

  // Data-phase FSM: outputs
  always_comb begin
    dp_active = (dp_state == DP_ACTIVE);
    s_hwdata  = '0;
    m_hready  = '0;
    m_hresp   = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (dp_active && data_owner_q == IDX_W'(i)) begin
        s_hwdata   = m_hwdata[i*DATA_WIDTH +: DATA_WIDTH];
        m_hresp[i] = s_hresp;
      end
      // Phase owners follow the slave; idle bystanders see ready; a master
      // requesting without a grant is held off.
      if ((dp_active && data_owner_q == IDX_W'(i)) ||
          (sel_valid && sel_idx == IDX_W'(i)))
        m_hready[i] = s_hreadyout;
      else if (m_htrans[i*2 +: 2] == 2'b00)
        m_hready[i] = 1'b1;
      else
        m_hready[i] = 1'b0;
    end
  end

  assign dbg_dp_state   = dp_state;
  assign dbg_data_owner = data_owner_q;

`ifdef AHB_SLAVE_MUX_ONEHOT_CHECK_EN
  logic multi_hot;
  logic new_seq;
  assign multi_hot = (hgrant & (hgrant - 1'b1)) != '0;
  // A fresh owner must open with NONSEQ; SEQ on its first granted cycle is illegal.
  assign new_seq   = gnt_any && (!addr_valid_q || gnt_idx != addr_owner_q) &&
                     (s_htrans == 2'b11);

  always_ff @(posedge hclk) begin
    if (hreset)                   mux_err <= 1'b0;
    else if (multi_hot || new_seq) mux_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ahb_slave_mux_slave_7.sv
module tb_ahb_slave_mux_slave_7;
  localparam int MN = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  localparam int ID_HSEL   = 0;
  localparam int ID_HADDR  = 1;
  localparam int ID_HTRANS = 2;
  localparam int ID_HWDATA = 3;
  localparam int ID_HREADY = 4;
  localparam int ID_HRESP  = 5;
  localparam int ID_HWAIT  = 6;
  localparam int ID_DPST   = 7;
  localparam int ID_DOWN   = 8;
  localparam int ID_HRDATA = 9;
  localparam int ID_MUXERR = 10;

  logic              clk = 1'b0;
  logic              hreset;
  logic [MN-1:0]     hgrant;
  logic              arb_hsel;
  logic [MN*AW-1:0]  m_haddr;
  logic [MN*2-1:0]   m_htrans;
  logic [MN-1:0]     m_hwrite;
  logic [MN*3-1:0]   m_hsize;
  logic [MN*3-1:0]   m_hburst;
  logic [MN*DW-1:0]  m_hwdata;
  logic              s_hreadyout;
  logic              s_hresp;
  logic [DW-1:0]     s_hrdata;
  logic              s_hsel;
  logic [AW-1:0]     s_haddr;
  logic [1:0]        s_htrans;
  logic              s_hwrite;
  logic [2:0]        s_hsize;
  logic [2:0]        s_hburst;
  logic [DW-1:0]     s_hwdata;
  logic [MN-1:0]     m_hready;
  logic [MN-1:0]     m_hresp;
  logic [DW-1:0]     m_hrdata;
  logic              hwait;
  logic              dbg_dp_state;
  logic              dbg_data_owner;
`ifdef AHB_SLAVE_MUX_ONEHOT_CHECK_EN
  logic              mux_err;
`endif

  ahb_slave_mux_slave_7 #(.MASTER_NUM(MN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .hclk(clk), .hreset(hreset), .hgrant(hgrant), .arb_hsel(arb_hsel),
    .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite),
    .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hwdata(m_hwdata),
    .s_hreadyout(s_hreadyout), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
    .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans),
    .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
    .s_hwdata(s_hwdata), .m_hready(m_hready), .m_hresp(m_hresp),
    .m_hrdata(m_hrdata), .hwait(hwait),
`ifdef AHB_SLAVE_MUX_ONEHOT_CHECK_EN
    .mux_err(mux_err),
`endif
    .dbg_dp_state(dbg_dp_state), .dbg_data_owner(dbg_data_owner)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // entry = {cycle[15:0], signal id[3:0], expected value[31:0]}
  logic [51:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;

  function automatic string sig_name(input logic [3:0] id);
    case (id)
      ID_HSEL:   return "s_hsel";
      ID_HADDR:  return "s_haddr";
      ID_HTRANS: return "s_htrans";
      ID_HWDATA: return "s_hwdata";
      ID_HREADY: return "m_hready";
      ID_HRESP:  return "m_hresp";
      ID_HWAIT:  return "hwait";
      ID_DPST:   return "dp_state";
      ID_DOWN:   return "data_owner";
      ID_HRDATA: return "m_hrdata";
      default:   return "mux_err";
    endcase
  endfunction

  function automatic logic [31:0] get_actual(input logic [3:0] id);
    case (id)
      ID_HSEL:   return {31'd0, s_hsel};
      ID_HADDR:  return s_haddr;
      ID_HTRANS: return {30'd0, s_htrans};
      ID_HWDATA: return s_hwdata;
      ID_HREADY: return {30'd0, m_hready};
      ID_HRESP:  return {30'd0, m_hresp};
      ID_HWAIT:  return {31'd0, hwait};
      ID_DPST:   return {31'd0, dbg_dp_state};
      ID_DOWN:   return {31'd0, dbg_data_owner};
      ID_HRDATA: return m_hrdata;
`ifdef AHB_SLAVE_MUX_ONEHOT_CHECK_EN
      ID_MUXERR: return {31'd0, mux_err};
`endif
      default:   return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: outputs are stable half a cycle after the driver updates inputs.
  always @(negedge clk) begin
    logic [51:0] e;
    logic [31:0] act;
    while (exp_q.size() > 0 && exp_q[0][51:36] == cyc[15:0]) begin
      e   = exp_q.pop_front();
      act = get_actual(e[35:32]);
      n_total++;
      if (act === e[31:0]) n_pass++;
      else $display("FAIL %s cycle=%0d actual=0x%08h expected=0x%08h",
                    sig_name(e[35:32]), cyc, act, e[31:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int id, input logic [31:0] v);
    exp_q.push_back({cyc[15:0], 4'(id), v});
  endtask

  task automatic all_idle();
    hgrant = '0; arb_hsel = 1'b0;
    m_haddr = '0; m_htrans = '0; m_hwrite = '0; m_hsize = '0; m_hburst = '0;
    m_hwdata = '0;
    s_hreadyout = 1'b1; s_hresp = 1'b0; s_hrdata = '0;
  endtask

  task automatic set_m(input int m, input logic [1:0] t, input logic [31:0] a,
                       input logic w, input logic [2:0] b);
    m_htrans[m*2 +: 2] = t;
    m_haddr[m*AW +: AW] = a;
    m_hwrite[m] = w;
    m_hsize[m*3 +: 3] = 3'b010;
    m_hburst[m*3 +: 3] = b;
  endtask

  task automatic set_wd(input int m, input logic [31:0] d);
    m_hwdata[m*DW +: DW] = d;
  endtask

  task automatic grant(input logic [1:0] g);
    hgrant = g; arb_hsel = |g;
  endtask

  localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011;

  // ---------------- stimulus ----------------
  initial begin
    hreset = 1'b1;
    all_idle();
    tick(); tick();
    hreset = 1'b0;
    // reset state
    expect_v(ID_HSEL, 0); expect_v(ID_HTRANS, 0); expect_v(ID_HWDATA, 0);
    expect_v(ID_HRESP, 0); expect_v(ID_HREADY, 2'b11); expect_v(ID_DPST, 0);
`ifdef AHB_SLAVE_MUX_ONEHOT_CHECK_EN
    expect_v(ID_MUXERR, 0);
`endif

    // ---- master 0 single write ----
    tick(); grant(2'b01); set_m(0, NSEQ, 32'h100, 1'b1, SINGLE);
    expect_v(ID_HADDR, 32'h100); expect_v(ID_HSEL, 1); expect_v(ID_HTRANS, NSEQ);
    expect_v(ID_HREADY, 2'b11); expect_v(ID_DPST, 0);
    tick(); all_idle(); set_wd(0, 32'hA5A5A5A5);
    expect_v(ID_HWDATA, 32'hA5A5A5A5); expect_v(ID_HREADY, 2'b11);
    expect_v(ID_DPST, 1); expect_v(ID_DOWN, 0); expect_v(ID_HSEL, 0);
    expect_v(ID_HTRANS, IDLE);
    tick(); all_idle();
    expect_v(ID_DPST, 0); expect_v(ID_HWDATA, 0);

    // ---- master 1 INCR4 read with two wait states ----
    tick(); all_idle(); grant(2'b10); set_m(1, NSEQ, 32'h200, 1'b0, INCR4);
    expect_v(ID_HADDR, 32'h200); expect_v(ID_HSEL, 1); expect_v(ID_HREADY, 2'b11);
    tick(); set_m(1, SEQ, 32'h204, 1'b0, INCR4); s_hrdata = 32'hD000_0000;
    expect_v(ID_HADDR, 32'h204); expect_v(ID_HTRANS, SEQ); expect_v(ID_DPST, 1);
    expect_v(ID_DOWN, 1); expect_v(ID_HRDATA, 32'hD000_0000); expect_v(ID_HREADY, 2'b11);
    for (int k = 0; k < 2; k++) begin
      tick(); grant(2'b00); arb_hsel = 1'b1; set_m(1, SEQ, 32'h208, 1'b0, INCR4);
      s_hreadyout = 1'b0; s_hrdata = 32'hBAD0_0000;
      expect_v(ID_HADDR, 32'h208); expect_v(ID_HWAIT, 1); expect_v(ID_HREADY, 2'b01);
      expect_v(ID_DPST, 1); expect_v(ID_DOWN, 1);
    end
    tick(); grant(2'b10); s_hreadyout = 1'b1; s_hrdata = 32'hD000_0001;
    expect_v(ID_HADDR, 32'h208); expect_v(ID_HWAIT, 0); expect_v(ID_HREADY, 2'b11);
    expect_v(ID_HRDATA, 32'hD000_0001);
    tick(); set_m(1, SEQ, 32'h20C, 1'b0, INCR4); s_hrdata = 32'hD000_0002;
    expect_v(ID_HADDR, 32'h20C); expect_v(ID_HREADY, 2'b11); expect_v(ID_HRDATA, 32'hD000_0002);
    tick(); all_idle(); s_hrdata = 32'hD000_0003;
    expect_v(ID_HREADY, 2'b11); expect_v(ID_DPST, 1); expect_v(ID_DOWN, 1);
    expect_v(ID_HRDATA, 32'hD000_0003); expect_v(ID_HSEL, 0);
    tick(); all_idle();
    expect_v(ID_DPST, 0);

    // ---- handover: master 0 INCR4 write, then master 1 NONSEQ ----
    tick(); grant(2'b01); set_m(0, NSEQ, 32'h300, 1'b1, INCR4);
    expect_v(ID_HADDR, 32'h300);
    tick(); set_m(0, SEQ, 32'h304, 1'b1, INCR4); set_wd(0, 32'h0000_0C00);
    expect_v(ID_HADDR, 32'h304); expect_v(ID_HWDATA, 32'h0000_0C00);
    tick(); set_m(0, SEQ, 32'h308, 1'b1, INCR4); set_wd(0, 32'h0000_0C01);
    expect_v(ID_HWDATA, 32'h0000_0C01);
    tick(); set_m(0, SEQ, 32'h30C, 1'b1, INCR4); set_wd(0, 32'h0000_0C02);
    set_m(1, NSEQ, 32'h400, 1'b1, SINGLE);
    // master 1 requests without a grant: held off
    expect_v(ID_HADDR, 32'h30C); expect_v(ID_HWDATA, 32'h0000_0C02); expect_v(ID_HREADY, 2'b01);
    tick(); grant(2'b10); set_m(0, IDLE, 32'h0, 1'b0, SINGLE); set_wd(0, 32'h0000_0C03);
    set_wd(1, 32'h0000_1111);
    expect_v(ID_HADDR, 32'h400); expect_v(ID_HWDATA, 32'h0000_0C03);
    expect_v(ID_DOWN, 0); expect_v(ID_HREADY, 2'b11); expect_v(ID_DPST, 1);
    tick(); all_idle(); set_wd(0, 32'h0000_0C04); set_wd(1, 32'h0000_B00B);
    expect_v(ID_HWDATA, 32'h0000_B00B); expect_v(ID_DOWN, 1); expect_v(ID_DPST, 1);
    tick(); all_idle();
    expect_v(ID_DPST, 0);

    // ---- two-cycle ERROR during master 0 data phase ----
    tick(); grant(2'b01); set_m(0, NSEQ, 32'h500, 1'b1, SINGLE);
    expect_v(ID_HRESP, 2'b00);
    tick(); all_idle(); s_hreadyout = 1'b0; s_hresp = 1'b1;
    expect_v(ID_HRESP, 2'b01); expect_v(ID_HREADY, 2'b10); expect_v(ID_HWAIT, 1);
    tick(); s_hreadyout = 1'b1; s_hresp = 1'b1;
    expect_v(ID_HRESP, 2'b01); expect_v(ID_HREADY, 2'b11);
    tick(); all_idle();
    expect_v(ID_HRESP, 2'b00); expect_v(ID_DPST, 0);

    // ---- reset during a stalled data phase ----
    tick(); grant(2'b10); set_m(1, NSEQ, 32'h600, 1'b1, SINGLE);
    expect_v(ID_HADDR, 32'h600);
    tick(); all_idle(); s_hreadyout = 1'b0; set_wd(1, 32'h0000_DEAD); hreset = 1'b1;
    expect_v(ID_DPST, 1); expect_v(ID_HREADY, 2'b01); expect_v(ID_HWDATA, 32'h0000_DEAD);
    tick(); hreset = 1'b0; s_hresp = 1'b1;
    expect_v(ID_HSEL, 0); expect_v(ID_HREADY, 2'b11); expect_v(ID_HWDATA, 0);
    expect_v(ID_DPST, 0); expect_v(ID_HRESP, 0); expect_v(ID_HTRANS, IDLE);
    tick(); all_idle();

    // ---- multi-hot grant: lowest index wins ----
    tick(); grant(2'b11);
    set_m(0, NSEQ, 32'h700, 1'b1, SINGLE); set_m(1, NSEQ, 32'h800, 1'b1, SINGLE);
    expect_v(ID_HADDR, 32'h700); expect_v(ID_HREADY, 2'b01);
`ifdef AHB_SLAVE_MUX_ONEHOT_CHECK_EN
    expect_v(ID_MUXERR, 0);
`endif
    tick(); all_idle(); set_wd(0, 32'h0000_0077); set_wd(1, 32'h0000_0088);
    expect_v(ID_HWDATA, 32'h0000_0077); expect_v(ID_DOWN, 0);
`ifdef AHB_SLAVE_MUX_ONEHOT_CHECK_EN
    expect_v(ID_MUXERR, 1);
`endif
    tick(); all_idle(); hreset = 1'b1;
`ifdef AHB_SLAVE_MUX_ONEHOT_CHECK_EN
    expect_v(ID_MUXERR, 1);
`endif
    tick(); hreset = 1'b0;
    expect_v(ID_DPST, 0);
`ifdef AHB_SLAVE_MUX_ONEHOT_CHECK_EN
    expect_v(ID_MUXERR, 0);
`endif

    // ---- drain and report ----
    tick(); tick();
    while (exp_q.size() > 0) begin
      logic [51:0] e;
      e = exp_q.pop_front();
      n_total++;
      $display("FAIL %s never checked (cycle %0d)", sig_name(e[35:32]), e[51:36]);
    end

    // idle end state
    n_total++;
    if (s_hsel === 1'b0) n_pass++;
    else $display("FAIL end s_hsel actual=%0b expected=0", s_hsel);
    n_total++;
    if (s_htrans === IDLE) n_pass++;
    else $display("FAIL end s_htrans actual=%0b expected=00", s_htrans);
    n_total++;
    if (m_hready === 2'b11) n_pass++;
    else $display("FAIL end m_hready actual=%0b expected=11", m_hready);
    n_total++;
    if (dbg_dp_state === 1'b0) n_pass++;
    else $display("FAIL end dp_state actual=%0b expected=0", dbg_dp_state);
    n_total++;
    if (s_hwdata === '0) n_pass++;
    else $display("FAIL end s_hwdata actual=0x%08h expected=0", s_hwdata);
    n_total++;
    if (m_hresp === 2'b00) n_pass++;
    else $display("FAIL end m_hresp actual=%0b expected=00", m_hresp);

    $display("%0d/%0d checks passed", n_pass, n_total);
    if (n_pass == n_total && n_total >= 12 && exp_q.size() == 0) $display("PASS");
    else $display("FAIL %0d check(s) failed", n_total - n_pass);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mux_slave_7.md
Name: ahb_slave_mux_slave_7

Overview:
- Slave-side address/data multiplexer placed directly downstream of the slave-7 arbiter.
- Consumes the arbiter's one-hot hgrant and hsel, and routes the granted master's address-phase signals to slave 7.
- Pipelines write-data routing by one AHB data phase and returns hready/hresp to the owning master.
- Produces the hwait signal that the arbiter uses to stall grant updates and burst counting.

Parameters:
- MASTER_NUM, 2, number of masters connected to slave 7; must match the arbiter.
- ADDR_WIDTH, 32, haddr width.
- DATA_WIDTH, 32, hwdata/hrdata width.

Ports:
- hclk  in  1  system clock; all state on rising edge.
- hreset  in  1  synchronous, active-high reset.
- hgrant  in  MASTER_NUM  one-hot grant from arbiter; already gated by ~hwait.
- arb_hsel  in  1  arbiter hsel (|grant).
- m_haddr  in  MASTER_NUM*ADDR_WIDTH  per-master address, packed, master i at [i].
- m_htrans  in  MASTER_NUM*2  per-master htrans.
- m_hwrite  in  MASTER_NUM  per-master hwrite.
- m_hsize  in  MASTER_NUM*3  per-master hsize.
- m_hburst  in  MASTER_NUM*3  per-master hburst (hburst_type encoding).
- m_hwdata  in  MASTER_NUM*DATA_WIDTH  per-master write data.
- s_hreadyout  in  1  slave ready.
- s_hresp  in  1  slave response: 0 = OKAY, 1 = ERROR.
- s_hrdata  in  DATA_WIDTH  slave read data.
- s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hwdata  out  (matching widths)  muxed signals to slave.
- m_hready  out  MASTER_NUM  per-master hready.
- m_hresp  out  MASTER_NUM  per-master hresp.
- m_hrdata  out  DATA_WIDTH  broadcast read data (equal to s_hrdata).
- hwait  out  1  equals ~s_hreadyout; drives the arbiter's hwait.

Behaviour:
- State registers:
  - addr_owner_q: index of the master holding the address phase.
  - addr_valid_q.
  - data_owner_q.
  - data_active_q.
- Address select:
  - If hgrant != 0: select index of the set bit, and update addr_owner_q <= that index, addr_valid_q <= 1.
  - Else if hwait = 1 and addr_valid_q = 1: select addr_owner_q. This holds the stalled address phase while the arbiter masks hgrant.
  - Else: no selection; addr_valid_q <= 0 on the next edge when hwait = 0.
- Slave outputs with a selection:
  - s_haddr/htrans/hwrite/hsize/hburst = the selected master's values.
  - s_hsel = arb_hsel.
- Slave outputs without a selection: s_hsel = 0, s_htrans = IDLE (2'b00), s_haddr/hwrite/hsize/hburst = 0.
- Data-phase FSM, states DP_IDLE and DP_ACTIVE:
  - Both states advance only on edges where s_hreadyout = 1.
  - On each such edge: data_owner_q <= selected index; data_active_q <= selection present and s_htrans in {NONSEQ, SEQ}.
  - DP_ACTIVE is entered when data_active_q is set; it returns to DP_IDLE when a ready edge carries no valid transfer.
  - While s_hreadyout = 0, the FSM and data_owner_q hold.
- s_hwdata = m_hwdata[data_owner_q] in DP_ACTIVE; 0 in DP_IDLE.
- Latency: s_hwdata lags the address-phase select by exactly one accepted transfer. Address outputs are combinational from inputs and state.
- m_hready[i]:
  - = s_hreadyout if (DP_ACTIVE and i = data_owner_q) or i = current selected index.
  - = 1 when i is idle and ungranted, with no transfer pending (m_htrans[i] = IDLE).
  - = 0 otherwise, which stalls ungranted requesters.
- m_hresp[i] = s_hresp if DP_ACTIVE and i = data_owner_q; else 0. Two-cycle ERROR is passed through unchanged.
- Reset (hreset = 1 at an edge):
  - All state registers cleared; FSM = DP_IDLE.
  - Outputs next cycle: s_hsel = 0, s_htrans = IDLE, s_hwdata = 0, m_hresp = 0, m_hready = all 1.
  - Reset mid-burst discards ownership with no residual data phase.
- Owner handover on the same ready edge: the old owner completes its data phase while the new owner's address is presented. There is no bubble.
- Multi-hot hgrant: the lowest set index wins.

Optional Feature:
- Macro: AHB_SLAVE_MUX_ONEHOT_CHECK_EN.
- When defined:
  - Adds output mux_err (1 bit, reset 0).
  - mux_err is set, sticky until hreset, on any edge where hgrant has more than one bit set.
  - It is also set when the newly selected master presents htrans = SEQ on its first granted cycle.
- When undefined: no port is added and no check is made; lowest index still wins.

Test Plan:
- Master 0 single write, addr 0x100, data 0xA5A5A5A5, s_hreadyout = 1: s_haddr = 0x100 in cycle N; s_hwdata = 0xA5A5A5A5 and m_hready[0] = 1 in N+1; FSM back to DP_IDLE in N+2.
- Master 1 INCR4 read with s_hreadyout low for 2 cycles mid-burst (hgrant = 0 while stalled): s_haddr holds master 1's address; hwait = 1; m_hready[1] = 0 for 2 cycles; all four beats are delivered.
- Handover from master 0 INCR4 to master 1 NONSEQ on the same ready edge: s_hwdata is master 0's final beat while s_haddr is master 1's address; data_owner_q = 1 on the next ready edge.
- Slave ERROR (s_hresp = 1, s_hreadyout = 0 then 1) during master 0's data phase: m_hresp = 2'b01 for both cycles; m_hresp[1] = 0.
- hreset asserted during a stalled DP_ACTIVE phase: next cycle s_hsel = 0, m_hready = 2'b11, s_hwdata = 0.
- With AHB_SLAVE_MUX_ONEHOT_CHECK_EN, hgrant = 2'b11 for one cycle: master 0 is selected and mux_err = 1 until reset. Without the macro, master 0 is selected and no mux_err port exists.
